memory_bank_io: RTL and testbench

//   Unified program/data memory for the qtcore datapath, with two memory-mapped IO bytes at the top of the address space.
//   It is directly upstream of control_unit and supplies the instruction byte that the IR loads in FETCH.
//   It is also downstream of control_unit and consumes Memory_write_enable plus the address picked by Memory_address_mux_select.

---
 rtl/memory_bank_io.sv | 83 ++++++++
 tb/tb_memory_bank_io.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bank_io.sv
// Unified program/data memory with an output-port register and a synchronised input port
// at the top two addresses. Memory and output register form one serial scan chain.
module memory_bank_io #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              processor_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enable,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    input  logic              scan_enable,
    input  logic              scan_in,
    output logic              scan_out
);

    localparam int OUT_ADDR = (2 ** ADDR_W) - 2;
    localparam int IN_ADDR  = (2 ** ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);
    localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_ADDR);

    logic [DATA_W-1:0] mem_q [OUT_ADDR];
    logic [DATA_W-1:0] mem_d [OUT_ADDR];
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] in_sync1_q, in_sync2_q;

    // Chain order, LSB first: mem[0] .. mem[OUT_ADDR-1], then out_reg; shifts toward mem[0][0].
    always_comb begin
        mem_d = mem_q;
        out_d = out_q;
        if (scan_enable) begin
            for (int i = 0; i < OUT_ADDR - 1; i++) begin
                mem_d[i] = {mem_q[i+1][0], mem_q[i][DATA_W-1:1]};
            end
            mem_d[OUT_ADDR-1] = {out_q[0], mem_q[OUT_ADDR-1][DATA_W-1:1]};
            out_d = {scan_in, out_q[DATA_W-1:1]};
        end else if (write_enable && processor_enable) begin
            if (address < OUT_A) begin
                mem_d[address] = data_in;
            end else if (address == OUT_A) begin
                out_d = data_in;
            end
        end
    end

    // Memory is deliberately not reset so a scanned-in program survives a processor reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q      <= '0;
            in_sync1_q <= '0;
            in_sync2_q <= '0;
        end else begin
            out_q      <= out_d;
            in_sync1_q <= io_in;
            in_sync2_q <= in_sync1_q;
        end
    end

    always_comb begin
        data_out = '0;
        if (address < OUT_A) begin
            data_out = mem_q[address];
        end else if (address == OUT_A) begin
            data_out = out_q;
        end else if (address == IN_A) begin
            data_out = in_sync2_q;
        end
    end

    assign io_out   = out_q;
    assign scan_out = mem_q[0][0];

endmodule

// File: tb/tb_memory_bank_io.sv
// Directed self-checking bench for memory_bank_io: reset, scan load/replay, functional
// read/write, IO port and synchroniser, priority and reset during scan.
module tb_memory_bank_io;

    logic       clk = 1'b0;
    logic       rst;
    logic       processor_enable;
    logic [4:0] address;
    logic [7:0] data_in;
    logic       write_enable;
    logic [7:0] data_out;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;

    int tests = 0;
    int fails = 0;

    logic [247:0] img;
    logic [247:0] c_m;

    memory_bank_io dut (
        .clk              (clk),
        .rst              (rst),
        .processor_enable (processor_enable),
        .address          (address),
        .data_in          (data_in),
        .write_enable     (write_enable),
        .data_out         (data_out),
        .io_in            (io_in),
        .io_out           (io_out),
        .scan_enable      (scan_enable),
        .scan_in          (scan_in),
        .scan_out         (scan_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic shift_bit(input logic b);
        scan_enable = 1'b1;
        scan_in     = b;
        tick();
        c_m = {b, c_m[247:1]};
        scan_enable = 1'b0;
    endtask

    task automatic check_all_mem(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 30; i++) begin
            rd(5'(i), d);
            tests++;
            if (d !== c_m[i*8 +: 8] || $isunknown(d)) begin
                fails++;
                $display("FAIL %s mem[%0d]: got %h expected %h", tag, i, d, c_m[i*8 +: 8]);
            end
        end
        tests++;
        if (io_out !== c_m[247:240]) begin
            fails++;
            $display("FAIL %s io_out: got %h expected %h", tag, io_out, c_m[247:240]);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b0;
        io_in = 8'h33;
        tick();
        tick();
        tests++;
        if (io_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_io_out: got %h expected 00", io_out);
        end
        rd(5'd31, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_in_sync: got %h expected 00", d);
        end
        io_in = 8'h00;
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_scan_load();
        for (int i = 0; i < 30; i++) img[i*8 +: 8] = 8'(i + 1);
        img[247:240] = 8'h3C;
        c_m = 'x;
        for (int j = 0; j < 248; j++) shift_bit(img[j]);
        check_all_mem("scan_load");
        // replay: scan the same image back in so memory is left loaded
        for (int j = 0; j < 248; j++) begin
            #1;
            tests++;
            if (scan_out !== img[j]) begin
                fails++;
                $display("FAIL scan_replay bit %0d: got %b expected %b", j, scan_out, img[j]);
            end
            shift_bit(img[j]);
        end
        check_all_mem("scan_reload");
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        processor_enable = 1'b1;
        write_enable = 1'b1;
        data_in = 8'hA5;
        rd(5'd3, d);
        tests++;
        if (d !== 8'h04) begin
            fails++;
            $display("FAIL wr_before_edge: got %h expected 04", d);
        end
        tick();
        write_enable = 1'b0;
        rd(5'd3, d);
        tests++;
        if (d !== 8'hA5) begin
            fails++;
            $display("FAIL wr_addr3: got %h expected a5", d);
        end
        rd(5'd4, d);
        tests++;
        if (d !== 8'h05) begin
            fails++;
            $display("FAIL wr_addr4_untouched: got %h expected 05", d);
        end
        c_m[31:24] = 8'hA5;
    endtask

    task automatic test_enable_gate();
        logic [7:0] d;
        processor_enable = 1'b0;
        write_enable = 1'b1;
        address = 5'd3;
        data_in = 8'h11;
        tick();
        write_enable = 1'b0;
        rd(5'd3, d);
        tests++;
        if (d !== 8'hA5) begin
            fails++;
            $display("FAIL enable_gate: got %h expected a5", d);
        end
        processor_enable = 1'b1;
    endtask

    task automatic test_io();
        logic [7:0] d;
        address = 5'd30;
        data_in = 8'h7E;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        tests++;
        if (io_out !== 8'h7E) begin
            fails++;
            $display("FAIL io_out_write: got %h expected 7e", io_out);
        end
        rd(5'd30, d);
        tests++;
        if (d !== 8'h7E) begin
            fails++;
            $display("FAIL io_out_readback: got %h expected 7e", d);
        end
        c_m[247:240] = 8'h7E;
        io_in = 8'h5A;
        tick();
        rd(5'd31, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL in_sync_edge1: got %h expected 00", d);
        end
        tick();
        rd(5'd31, d);
        tests++;
        if (d !== 8'h5A) begin
            fails++;
            $display("FAIL in_sync_edge2: got %h expected 5a", d);
        end
        data_in = 8'hFF;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        rd(5'd31, d);
        tests++;
        if (d !== 8'h5A) begin
            fails++;
            $display("FAIL write_in_addr: got %h expected 5a", d);
        end
        check_all_mem("write_in_addr_state");
    endtask

    task automatic test_priority();
        address = 5'd5;
        data_in = 8'hEE;
        write_enable = 1'b1;
        processor_enable = 1'b1;
        shift_bit(1'b1);
        write_enable = 1'b0;
        check_all_mem("scan_over_write");
        rst = 1'b0;
        scan_enable = 1'b1;
        scan_in = 1'b1;
        tick();
        scan_enable = 1'b0;
        rst = 1'b1;
        c_m[247:240] = 8'h00;
        check_all_mem("rst_over_scan");
    endtask

    task automatic test_reset_mid_scan();
        logic [247:0] n;
        for (int i = 0; i < 31; i++) n[i*8 +: 8] = 8'hC3 ^ 8'(i * 5);
        for (int j = 0; j < 100; j++) shift_bit(n[j]);
        rst = 1'b0;
        scan_enable = 1'b1;
        scan_in = 1'b1;
        tick();
        scan_enable = 1'b0;
        rst = 1'b1;
        c_m[247:240] = 8'h00;
        for (int j = 100; j < 248; j++) shift_bit(n[j]);
        check_all_mem("reset_mid_scan");
    endtask

    initial begin
        rst = 1'b0;
        processor_enable = 1'b0;
        address = '0;
        data_in = '0;
        write_enable = 1'b0;
        io_in = '0;
        scan_enable = 1'b0;
        scan_in = 1'b0;
        img = '0;
        c_m = '0;
        @(negedge clk);
        test_reset();
        test_scan_load();
        test_write_read();
        test_enable_gate();
        test_io();
        test_priority();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
